mmcm_reconf_sched: RTL and testbench

// Sequences run-time MMCM reconfiguration for framerate switching (60 Hz <-> 59.7 Hz).
// - Synchronises and debounces the requested framerate, then issues one doSwitch/stateSel command to drp.
// - Tracks drp busy and MMCM lock, retries on timeout, and holds the video pipeline in reset until clocks are stable.
// - Sits in the 100 MHz clk domain, between imageGenV's framerate output and the drp instance.

---
 rtl/mmcm_reconf_sched_pkg.sv | 23 ++
 rtl/mmcm_reconf_sched_sync2ff.sv | 24 ++
 rtl/mmcm_reconf_sched.sv | 182 ++++++++++++++++++
 tb/tb_mmcm_reconf_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_reconf_sched_pkg.sv
// Shared types and helpers for the MMCM reconfiguration scheduler.
// Covers scheduler state encoding, rate codes and DRP select formatting.
package mmcm_reconf_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE,
      WAIT_LOCK,
      HOLD,
      FAULT
   } sched_state_t;

   localparam logic RATE_60 = 1'b0;
   localparam logic RATE_59 = 1'b1;

   function automatic logic [2:0] state_sel_of(input logic [1:0] res, input logic rate);
      return {res, rate};
   endfunction

endpackage

// File: rtl/mmcm_reconf_sched_sync2ff.sv
// Two-flop bit synchroniser with asynchronous active-low reset.
module mmcm_reconf_sched_sync2ff (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_q    <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/mmcm_reconf_sched.sv
// Sequences MMCM DRP reconfiguration for 60 Hz <-> 59.7 Hz switching, with
// request debounce, ack/lock timeouts, bounded retries and pipeline reset hold.
module mmcm_reconf_sched
   import mmcm_reconf_sched_pkg::*;
#(
   parameter int unsigned RES_SEL      = 2,
   parameter int unsigned SETTLE_CYC   = 1024,
   parameter int unsigned ACK_TIMEOUT  = 64,
   parameter int unsigned LOCK_TIMEOUT = 1048576,
   parameter int unsigned HOLD_CYC     = 256,
   parameter int unsigned MAX_RETRY    = 3
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_framerate,
   input  logic       i_drp_busy,
   input  logic       i_mmcm_locked,
   output logic       o_do_switch,
   output logic [2:0] o_state_sel,
   output logic       o_pipe_rst,
   output logic       o_sched_busy,
   output logic       o_applied_rate,
   output logic       o_fault
);

   localparam int unsigned W_SET = $clog2(SETTLE_CYC) + 1;
   localparam int unsigned W_ACK = $clog2(ACK_TIMEOUT) + 1;
   localparam int unsigned W_LCK = $clog2(LOCK_TIMEOUT) + 1;
   localparam int unsigned W_HLD = $clog2(HOLD_CYC) + 1;
   localparam int unsigned W_A   = (W_SET > W_ACK) ? W_SET : W_ACK;
   localparam int unsigned W_B   = (W_LCK > W_HLD) ? W_LCK : W_HLD;
   localparam int unsigned TW    = (W_A > W_B) ? W_A : W_B;
   localparam int unsigned RW    = $clog2(MAX_RETRY) + 1;

   localparam logic [1:0]    RES       = 2'(RES_SEL);
   localparam logic [TW-1:0] SET_LAST  = TW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
   localparam logic [TW-1:0] LCK_LAST  = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] HLD_LAST  = TW'(HOLD_CYC - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   sched_state_t  r_state, w_state_d;
   logic [TW-1:0] r_tmr, w_tmr_d, w_tmr_inc;
   logic [RW-1:0] r_retry, w_retry_d;
   logic          r_target, w_target_d;
   logic          r_applied, w_applied_d;
   logic [2:0]    r_sel, w_sel_d;
   logic          w_retry_go;
   logic          w_req_s;
   logic          w_lock_s;

   mmcm_reconf_sched_sync2ff u_sync_req (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_framerate),
      .o_q     (w_req_s)
   );

   mmcm_reconf_sched_sync2ff u_sync_lock (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_mmcm_locked),
      .o_q     (w_lock_s)
   );

   assign w_tmr_inc = (r_tmr == '1) ? r_tmr : r_tmr + 1'b1;

   always_comb begin
      w_state_d   = r_state;
      w_tmr_d     = r_tmr;
      w_retry_d   = r_retry;
      w_target_d  = r_target;
      w_applied_d = r_applied;
      w_retry_go  = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_lock_s) begin
               w_state_d = HOLD;
               w_tmr_d   = '0;
            end else if (w_req_s != r_applied) begin
               w_state_d = SETTLE;
               w_tmr_d   = '0;
               w_retry_d = '0;
            end
         end
         SETTLE: begin
            // A 1-bit request that toggles inside SETTLE can only fall back onto appliedRate.
            if (w_req_s == r_applied) begin
               w_state_d = IDLE;
            end else if (r_tmr >= SET_LAST) begin
               if (!i_drp_busy) begin
                  w_target_d = w_req_s ? RATE_59 : RATE_60;
                  w_state_d  = ISSUE;
                  w_tmr_d    = '0;
               end
            end else begin
               w_tmr_d = w_tmr_inc;
            end
         end
         ISSUE: begin
            w_state_d = WAIT_ACK;
            w_tmr_d   = w_tmr_inc;
         end
         WAIT_ACK: begin
            if (i_drp_busy) begin
               w_state_d = WAIT_DONE;
            end else if (r_tmr >= ACK_LAST) begin
               w_retry_go = 1'b1;
            end else begin
               w_tmr_d = w_tmr_inc;
            end
         end
         WAIT_DONE: begin
            if (!i_drp_busy) begin
               w_state_d = WAIT_LOCK;
               w_tmr_d   = '0;
            end
         end
         WAIT_LOCK: begin
            if (w_lock_s) begin
               w_state_d = HOLD;
               w_tmr_d   = '0;
            end else if (r_tmr >= LCK_LAST) begin
               w_retry_go = 1'b1;
            end else begin
               w_tmr_d = w_tmr_inc;
            end
         end
         HOLD: begin
            if (!w_lock_s) begin
               w_tmr_d = '0;
            end else if (r_tmr >= HLD_LAST) begin
               w_applied_d = r_target;
               w_state_d   = IDLE;
            end else begin
               w_tmr_d = w_tmr_inc;
            end
         end
         FAULT: begin
            w_state_d = FAULT;
         end
      endcase

      if (w_retry_go) begin
         if (r_retry < RETRY_MAX) begin
            w_retry_d = r_retry + 1'b1;
            w_state_d = ISSUE;
            w_tmr_d   = '0;
         end else begin
            w_state_d = FAULT;
         end
      end

      w_sel_d = (w_state_d == ISSUE) ? state_sel_of(RES, w_target_d) : r_sel;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= HOLD;
         r_tmr     <= '0;
         r_retry   <= '0;
         r_target  <= RATE_60;
         r_applied <= RATE_60;
         r_sel     <= state_sel_of(RES, RATE_60);
      end else begin
         r_state   <= w_state_d;
         r_tmr     <= w_tmr_d;
         r_retry   <= w_retry_d;
         r_target  <= w_target_d;
         r_applied <= w_applied_d;
         r_sel     <= w_sel_d;
      end
   end

   assign o_do_switch    = (r_state == ISSUE);
   assign o_state_sel    = r_sel;
   assign o_pipe_rst     = !(r_state == IDLE || r_state == SETTLE || r_state == FAULT);
   assign o_sched_busy   = !(r_state == IDLE || r_state == FAULT);
   assign o_applied_rate = r_applied;
   assign o_fault        = (r_state == FAULT);

endmodule

// File: tb/tb_mmcm_reconf_sched.sv
// Directed bench for mmcm_reconf_sched with a simple DRP/MMCM behavioural model.
module tb_mmcm_reconf_sched;

   localparam int SC = 16;
   localparam int AT = 8;
   localparam int LT = 200;
   localparam int HC = 12;
   localparam int MR = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       framerate = 1'b0;
   logic       drp_busy;
   logic       mmcm_locked;
   logic       o_do_switch;
   logic [2:0] o_state_sel;
   logic       o_pipe_rst;
   logic       o_sched_busy;
   logic       o_applied_rate;
   logic       o_fault;

   // Model: busy for 20 cycles after each doSwitch, lock returns 50 cycles after busy drops.
   logic model_en = 1'b0;
   logic lock_req = 1'b0;
   logic busy_mdl = 1'b0;
   logic lock_mdl = 1'b1;
   int   busy_left = 0;
   int   lock_left = 0;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   n_sw = 0;
   int   sw_times[32];
   logic sw_prev = 1'b0;
   logic consec = 1'b0;

   assign drp_busy    = model_en ? busy_mdl : 1'b0;
   assign mmcm_locked = model_en ? lock_mdl : lock_req;

   mmcm_reconf_sched #(
      .RES_SEL      (1),
      .SETTLE_CYC   (SC),
      .ACK_TIMEOUT  (AT),
      .LOCK_TIMEOUT (LT),
      .HOLD_CYC     (HC),
      .MAX_RETRY    (MR)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_framerate    (framerate),
      .i_drp_busy     (drp_busy),
      .i_mmcm_locked  (mmcm_locked),
      .o_do_switch    (o_do_switch),
      .o_state_sel    (o_state_sel),
      .o_pipe_rst     (o_pipe_rst),
      .o_sched_busy   (o_sched_busy),
      .o_applied_rate (o_applied_rate),
      .o_fault        (o_fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (o_do_switch) begin
         if (sw_prev) consec = 1'b1;
         if (n_sw < 32) sw_times[n_sw] = cyc;
         n_sw++;
      end
      sw_prev = o_do_switch;
   end

   always @(negedge clk) begin
      if (model_en && o_do_switch) begin
         busy_mdl  = 1'b1;
         lock_mdl  = 1'b0;
         busy_left = 20;
         lock_left = 0;
      end else if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) begin
            busy_mdl  = 1'b0;
            lock_left = 50;
         end
      end else if (lock_left > 0) begin
         lock_left--;
         if (lock_left == 0) lock_mdl = 1'b1;
      end
   end

   task automatic wait_sw(input int bound, output int n, output bit ok);
      ok = 1'b0;
      n  = 0;
      while (n < bound && !ok) begin
         @(posedge clk);
         n++;
         #1;
         if (o_do_switch) ok = 1'b1;
      end
   endtask

   task automatic wait_applied(input logic v, input int bound, output bit ok);
      int n = 0;
      ok = 1'b0;
      while (n < bound && !ok) begin
         @(posedge clk);
         n++;
         #1;
         if (o_applied_rate === v) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      int  n;
      bit  ok;
      repeat (3) @(negedge clk);
      checks++; if (o_do_switch !== 1'b0) begin errors++;
         $display("FAIL t1_rst_do_switch: got %b want 0", o_do_switch); end
      checks++; if (o_state_sel !== 3'b010) begin errors++;
         $display("FAIL t1_rst_state_sel: got %b want 010", o_state_sel); end
      checks++; if (o_pipe_rst !== 1'b1) begin errors++;
         $display("FAIL t1_rst_pipe_rst: got %b want 1", o_pipe_rst); end
      checks++; if (o_sched_busy !== 1'b1) begin errors++;
         $display("FAIL t1_rst_sched_busy: got %b want 1", o_sched_busy); end
      checks++; if (o_applied_rate !== 1'b0) begin errors++;
         $display("FAIL t1_rst_applied: got %b want 0", o_applied_rate); end
      checks++; if (o_fault !== 1'b0) begin errors++;
         $display("FAIL t1_rst_fault: got %b want 0", o_fault); end
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      lock_req = 1'b1;
      @(posedge clk);
      #1;
      n  = 0;
      ok = 1'b0;
      while (n < 100 && !ok) begin
         @(posedge clk);
         n++;
         #1;
         if (o_pipe_rst === 1'b0) ok = 1'b1;
      end
      checks++; if (!ok || n != 1 + HC) begin errors++;
         $display("FAIL t1_pipe_rst_release: got %0d cycles want %0d", n, 1 + HC); end
      checks++; if (n_sw !== 0) begin errors++;
         $display("FAIL t1_no_switch: got %0d pulses want 0", n_sw); end
      checks++; if (o_applied_rate !== 1'b0 || o_sched_busy !== 1'b0) begin errors++;
         $display("FAIL t1_idle: got applied=%b busy=%b want 0 0", o_applied_rate,
                  o_sched_busy); end
   endtask

   task automatic test_glitch;
      int   n0 = n_sw;
      logic pr_seen = 1'b0;
      for (int i = 0; i < 3 * SC; i++) begin
         @(negedge clk);
         if (o_pipe_rst) pr_seen = 1'b1;
         if (i == 0) framerate = 1'b1;
         if (i == SC / 2) framerate = 1'b0;
      end
      checks++; if (n_sw != n0) begin errors++;
         $display("FAIL t3_no_switch: got %0d pulses want 0", n_sw - n0); end
      checks++; if (pr_seen !== 1'b0) begin errors++;
         $display("FAIL t3_pipe_rst: got %b want 0", pr_seen); end
      checks++; if (o_applied_rate !== 1'b0) begin errors++;
         $display("FAIL t3_applied: got %b want 0", o_applied_rate); end
   endtask

   task automatic test_switch_up;
      int n;
      int n0;
      bit ok;
      model_en = 1'b1;
      n0 = n_sw;
      @(negedge clk);
      framerate = 1'b1;
      @(posedge clk);
      #1;
      wait_sw(SC + 50, n, ok);
      checks++; if (!ok || n != 2 + SC) begin errors++;
         $display("FAIL t2_latency: got %0d cycles (seen=%0d) want %0d", n, ok, 2 + SC); end
      checks++; if (o_state_sel !== 3'b011) begin errors++;
         $display("FAIL t2_state_sel: got %b want 011", o_state_sel); end
      wait_applied(1'b1, 400, ok);
      checks++; if (!ok) begin errors++;
         $display("FAIL t2_applied: got %b want 1", o_applied_rate); end
      checks++; if (o_pipe_rst !== 1'b0 || o_sched_busy !== 1'b0) begin errors++;
         $display("FAIL t2_idle: got pipe_rst=%b busy=%b want 0 0", o_pipe_rst,
                  o_sched_busy); end
      checks++; if (n_sw - n0 != 1) begin errors++;
         $display("FAIL t2_one_pulse: got %0d pulses want 1", n_sw - n0); end
   endtask

   task automatic test_switch_down;
      int n;
      bit ok;
      @(negedge clk);
      framerate = 1'b0;
      wait_sw(SC + 50, n, ok);
      checks++; if (!ok || o_state_sel !== 3'b010) begin errors++;
         $display("FAIL down_state_sel: got %b (seen=%0d) want 010", o_state_sel, ok); end
      wait_applied(1'b0, 400, ok);
      checks++; if (!ok || o_pipe_rst !== 1'b0) begin errors++;
         $display("FAIL down_applied: got applied=%b pipe_rst=%b want 0 0", o_applied_rate,
                  o_pipe_rst); end
   endtask

   task automatic test_coalesce;
      int n;
      int n0;
      bit ok;
      n0 = n_sw;
      @(negedge clk);
      framerate = 1'b1;
      wait_sw(SC + 50, n, ok);
      repeat (35) @(negedge clk);
      framerate = 1'b0;
      wait_applied(1'b1, 400, ok);
      checks++; if (!ok) begin errors++;
         $display("FAIL t4_first_applied: got %b want 1", o_applied_rate); end
      checks++; if (n_sw - n0 != 1) begin errors++;
         $display("FAIL t4_first_pulses: got %0d want 1", n_sw - n0); end
      wait_sw(SC + 50, n, ok);
      checks++; if (!ok || o_state_sel[0] !== 1'b0) begin errors++;
         $display("FAIL t4_second_sel: got %b (seen=%0d) want lsb 0", o_state_sel, ok); end
      wait_applied(1'b0, 400, ok);
      checks++; if (!ok) begin errors++;
         $display("FAIL t4_second_applied: got %b want 0", o_applied_rate); end
   endtask

   task automatic test_retry_fault;
      int n0;
      int n = 0;
      bit ok = 1'b0;
      model_en = 1'b0;
      lock_req = 1'b1;
      n0 = n_sw;
      @(negedge clk);
      framerate = 1'b1;
      while (n < 300 && !ok) begin
         @(posedge clk);
         n++;
         #1;
         if (o_fault === 1'b1) ok = 1'b1;
      end
      checks++; if (!ok) begin errors++;
         $display("FAIL t5_fault: got %b want 1", o_fault); end
      checks++; if (n_sw - n0 != MR + 1) begin errors++;
         $display("FAIL t5_pulses: got %0d want %0d", n_sw - n0, MR + 1); end
      for (int i = 0; i < MR; i++) begin
         checks++;
         if (sw_times[n0 + i + 1] - sw_times[n0 + i] != AT) begin errors++;
            $display("FAIL t5_interval%0d: got %0d want %0d", i,
                     sw_times[n0 + i + 1] - sw_times[n0 + i], AT); end
      end
      checks++; if (o_pipe_rst !== 1'b0 || o_sched_busy !== 1'b0) begin errors++;
         $display("FAIL t5_outputs: got pipe_rst=%b busy=%b want 0 0", o_pipe_rst,
                  o_sched_busy); end
      repeat (40) @(negedge clk);
      checks++; if (n_sw - n0 != MR + 1 || o_fault !== 1'b1) begin errors++;
         $display("FAIL t5_sticky: got pulses=%0d fault=%b want %0d 1", n_sw - n0, o_fault,
                  MR + 1); end
   endtask

   task automatic test_reset_mid_op;
      int n;
      int n0;
      bit ok;
      model_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (o_fault !== 1'b0 || o_pipe_rst !== 1'b1) begin errors++;
         $display("FAIL t6_fault_clear: got fault=%b pipe_rst=%b want 0 1", o_fault,
                  o_pipe_rst); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_sw(300, n, ok);
      checks++; if (!ok || o_state_sel !== 3'b011) begin errors++;
         $display("FAIL t6_first_issue: got %b (seen=%0d) want 011", o_state_sel, ok); end
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (o_do_switch !== 1'b0 || o_state_sel !== 3'b010 || o_pipe_rst !== 1'b1 ||
          o_sched_busy !== 1'b1 || o_applied_rate !== 1'b0 || o_fault !== 1'b0) begin
         errors++;
         $display("FAIL t6_async_rst: got sw=%b sel=%b prst=%b busy=%b app=%b flt=%b want 0 010 1 1 0 0",
                  o_do_switch, o_state_sel, o_pipe_rst, o_sched_busy, o_applied_rate, o_fault);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      n0 = n_sw;
      wait_sw(400, n, ok);
      checks++; if (!ok || o_state_sel !== 3'b011) begin errors++;
         $display("FAIL t6_reissue: got %b (seen=%0d) want 011", o_state_sel, ok); end
      wait_applied(1'b1, 400, ok);
      checks++; if (!ok || n_sw - n0 != 1) begin errors++;
         $display("FAIL t6_complete: got applied=%b pulses=%0d want 1 1", o_applied_rate,
                  n_sw - n0); end
      checks++; if (consec !== 1'b0) begin errors++;
         $display("FAIL back_to_back_pulse: got %b want 0", consec); end
   endtask

   initial begin
      test_reset;
      test_glitch;
      test_switch_up;
      test_switch_down;
      test_coalesce;
      test_retry_fault;
      test_reset_mid_op;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
